// File: rtl/dinorun_pkg.sv
// Shared types and constants for the dinorun obstacle scheduling logic.
package dinorun_pkg;

  localparam int NumObstacleSlots = 3;
  localparam int LevelW           = 3;

  typedef enum logic [1:0] {
    IDLE,
    COOLDOWN,
    ARMED
  } sched_state_t;

  // Clamp a 9-bit sum into the 8-bit range.
  function automatic logic [7:0] sat8(input logic [8:0] value);
    return value[8] ? 8'hFF : value[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting slot at or after ptr_i, with wrap-around.
module rr_arbiter #(
  parameter int NumSlots = 3,
  parameter int IdxW     = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic [NumSlots-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  input  logic                en_i,
  output logic [NumSlots-1:0] grant_o,
  output logic [IdxW-1:0]     grant_idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < NumSlots; i++) begin
      cand = IdxW'((int'(ptr_i) + i) % NumSlots);
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Per-frame obstacle spawn scheduler: cooldown gap, difficulty level and round-robin slot choice.
module spawn_scheduler
  import dinorun_pkg::*;
#(
  parameter int                  NumSlots     = NumObstacleSlots,
  parameter logic [NumSlots-1:0] BirdMask     = NumSlots'(1),
  parameter int                  BirdMinLevel = 2,
  parameter int                  BaseGap      = 60,
  parameter int                  GapStep      = 4,
  parameter int                  MinGap       = 20,
  parameter int                  LevelFrames  = 300,
  parameter int                  MaxLevel     = 7,
  parameter int                  SpawnThresh  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_i,
  input  logic                run_i,
  input  logic                clear_i,
  input  logic [15:0]         rand_i,
  input  logic [NumSlots-1:0] slot_free_i,
  output logic [NumSlots-1:0] spawn_o,
  output logic [1:0]          variant_o,
  output logic [LevelW-1:0]   level_o,
  output logic                armed_o
);

  localparam int IdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int CntW = $clog2(LevelFrames);

  sched_state_t      state_q, state_d;
  logic [7:0]        cooldown_q, cooldown_d;
  logic [CntW-1:0]   lvl_cnt_q, lvl_cnt_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic              started_q, started_d;

  logic [NumSlots-1:0] eligible;
  logic [NumSlots-1:0] grant;
  logic [IdxW-1:0]     grant_idx;
  logic                birds_blocked;
  logic [7:0]          thresh;
  logic                attempt;
  logic                granted;
  logic                unused_rand;

  function automatic logic [7:0] gapFor(input logic [LevelW-1:0] lvl);
    logic [7:0] step;
    step = 8'(GapStep) * 8'(lvl);
    if (step >= 8'(BaseGap) || (8'(BaseGap) - step) < 8'(MinGap)) begin
      return 8'(MinGap);
    end
    return 8'(BaseGap) - step;
  endfunction

  assign birds_blocked = int'(level_q) < BirdMinLevel;
  assign eligible      = slot_free_i & ~(BirdMask & {NumSlots{birds_blocked}});
  assign thresh        = sat8(9'(SpawnThresh) + {2'b00, level_q, 4'b0000});
  assign attempt       = run_i && !clear_i && frame_i && (state_q == ARMED) &&
                         (rand_i[7:0] < thresh);
  assign unused_rand   = ^rand_i[15:8];

  rr_arbiter #(
    .NumSlots(NumSlots),
    .IdxW    (IdxW)
  ) u_arbiter (
    .req_i      (eligible),
    .ptr_i      (ptr_q),
    .en_i       (attempt),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  assign granted   = |grant;
  assign spawn_o   = grant;
  assign variant_o = granted ? rand_i[3:2] : 2'b00;
  assign level_o   = level_q;
  assign armed_o   = (state_q == ARMED);

  // started_q tells a fresh game (load a full gap) apart from resuming after a freeze.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    lvl_cnt_d  = lvl_cnt_q;
    level_d    = level_q;
    ptr_d      = ptr_q;
    started_d  = started_q;

    if (clear_i) begin
      state_d    = IDLE;
      cooldown_d = '0;
      lvl_cnt_d  = '0;
      level_d    = '0;
      ptr_d      = '0;
      started_d  = 1'b0;
    end else begin
      if (frame_i && run_i) begin
        if (lvl_cnt_q == CntW'(LevelFrames - 1)) begin
          lvl_cnt_d = '0;
          if (level_q != LevelW'(MaxLevel)) level_d = level_q + LevelW'(1);
        end else begin
          lvl_cnt_d = lvl_cnt_q + CntW'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (run_i) begin
            started_d = 1'b1;
            if (!started_q) begin
              state_d    = COOLDOWN;
              cooldown_d = gapFor(level_q);
            end else if (cooldown_q == 8'd0) begin
              state_d = ARMED;
            end else begin
              state_d = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (!run_i) begin
            state_d = IDLE;
          end else if (frame_i) begin
            if (cooldown_q <= 8'd1) begin
              cooldown_d = '0;
              state_d    = ARMED;
            end else begin
              cooldown_d = cooldown_q - 8'd1;
            end
          end
        end
        ARMED: begin
          if (!run_i) begin
            state_d = IDLE;
          end else if (granted) begin
            ptr_d      = (grant_idx == IdxW'(NumSlots - 1)) ? '0 : grant_idx + IdxW'(1);
            cooldown_d = gapFor(level_q);
            state_d    = COOLDOWN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cooldown_q <= '0;
      lvl_cnt_q  <= '0;
      level_q    <= '0;
      ptr_q      <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      lvl_cnt_q  <= lvl_cnt_d;
      level_q    <= level_d;
      ptr_q      <= ptr_d;
      started_q  <= started_d;
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed testbench for spawn_scheduler: frame pulses every other cycle, expected values worked out by hand.
module tb_spawn_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        frame_i;
  logic        run_i;
  logic        clear_i;
  logic [15:0] rand_i;
  logic [2:0]  slot_free_i;
  logic [2:0]  spawn_o;
  logic [1:0]  variant_o;
  logic [2:0]  level_o;
  logic        armed_o;

  int checks = 0;
  int errors = 0;

  int         spawnCount;
  int         spawnAt;
  logic [2:0] spawnVal;
  logic [1:0] varVal;
  logic       armedAllHigh;
  logic       sawMulti = 1'b0;

  spawn_scheduler dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .frame_i    (frame_i),
    .run_i      (run_i),
    .clear_i    (clear_i),
    .rand_i     (rand_i),
    .slot_free_i(slot_free_i),
    .spawn_o    (spawn_o),
    .variant_o  (variant_o),
    .level_o    (level_o),
    .armed_o    (armed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives n frame pulses (one cycle high, one low), sampling outputs mid-pulse.
  task automatic applyStimulus(input int n, input bit stopOnSpawn);
    spawnCount   = 0;
    spawnAt      = -1;
    spawnVal     = '0;
    varVal       = '0;
    armedAllHigh = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_i);
      frame_i = 1'b1;
      #1;
      if (!armed_o) armedAllHigh = 1'b0;
      if (spawn_o != 3'b000) begin
        spawnCount++;
        if ($countones(spawn_o) > 1) sawMulti = 1'b1;
        if (spawnAt < 0) begin
          spawnAt  = k;
          spawnVal = spawn_o;
          varVal   = variant_o;
        end
      end
      @(negedge clk_i);
      frame_i = 1'b0;
      if (stopOnSpawn && spawnCount > 0) break;
    end
  endtask

  task automatic doClear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    frame_i     = 1'b0;
    run_i       = 1'b0;
    clear_i     = 1'b0;
    rand_i      = 16'h0000;
    slot_free_i = 3'b111;
    #3;
    checkOutput("reset_spawn", 32'(spawn_o), 32'h0);
    checkOutput("reset_level", 32'(level_o), 32'h0);
    checkOutput("reset_armed", 32'(armed_o), 32'h0);
    checkOutput("reset_variant", 32'(variant_o), 32'h0);

    // Fresh game at level 0: bird slot 0 is skipped, first spawn after 60 cooldown frames.
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_i  = 1'b1;
    applyStimulus(100, 1'b1);
    checkOutput("t1_first_at", 32'(spawnAt), 32'd61);
    checkOutput("t1_first_val", 32'(spawnVal), 32'b010);
    rand_i = 16'h000C;
    applyStimulus(100, 1'b1);
    checkOutput("t1_second_at", 32'(spawnAt), 32'd61);
    checkOutput("t1_second_val", 32'(spawnVal), 32'b100);
    checkOutput("t1_variant", 32'(varVal), 32'd3);

    // Reach level 2 with no free slots, then check rotation with gap 52.
    rand_i      = 16'h0000;
    slot_free_i = 3'b000;
    doClear();
    applyStimulus(600, 1'b0);
    checkOutput("t2_level", 32'(level_o), 32'd2);
    checkOutput("t2_no_spawn", 32'(spawnCount), 32'd0);
    checkOutput("t2_armed", 32'(armed_o), 32'd1);
    slot_free_i = 3'b111;
    applyStimulus(1, 1'b1);
    checkOutput("t2_g0_val", 32'(spawnVal), 32'b001);
    applyStimulus(100, 1'b1);
    checkOutput("t2_g1_at", 32'(spawnAt), 32'd53);
    checkOutput("t2_g1_val", 32'(spawnVal), 32'b010);
    applyStimulus(100, 1'b1);
    checkOutput("t2_g2_at", 32'(spawnAt), 32'd53);
    checkOutput("t2_g2_val", 32'(spawnVal), 32'b100);
    applyStimulus(100, 1'b1);
    checkOutput("t2_g3_at", 32'(spawnAt), 32'd53);
    checkOutput("t2_g3_val", 32'(spawnVal), 32'b001);

    // Armed but nothing free; a frozen frame gives no pulse; resume goes straight to ARMED.
    slot_free_i = 3'b000;
    applyStimulus(52, 1'b0);
    checkOutput("t3_armed_after_cd", 32'(armed_o), 32'd1);
    applyStimulus(10, 1'b0);
    checkOutput("t3_no_spawn", 32'(spawnCount), 32'd0);
    checkOutput("t3_armed_held", 32'(armedAllHigh), 32'd1);
    @(negedge clk_i);
    slot_free_i = 3'b100;
    run_i       = 1'b0;
    frame_i     = 1'b1;
    #1;
    checkOutput("t3_run0_spawn", 32'(spawn_o), 32'h0);
    @(negedge clk_i);
    frame_i = 1'b0;
    checkOutput("t3_frozen_idle", 32'(armed_o), 32'd0);
    run_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t3_resume_armed", 32'(armed_o), 32'd1);
    applyStimulus(1, 1'b1);
    checkOutput("t3_free2_val", 32'(spawnVal), 32'b100);

    // Threshold at level 0 is 64: 0xFF and 0x40 fail, 0x3F succeeds.
    slot_free_i = 3'b111;
    rand_i      = 16'h00FF;
    doClear();
    applyStimulus(60, 1'b0);
    applyStimulus(20, 1'b0);
    checkOutput("t4_ff_no_spawn", 32'(spawnCount), 32'd0);
    checkOutput("t4_ff_armed", 32'(armedAllHigh), 32'd1);
    rand_i = 16'h0040;
    applyStimulus(1, 1'b0);
    checkOutput("t4_40_no_spawn", 32'(spawnCount), 32'd0);
    rand_i = 16'h003F;
    applyStimulus(1, 1'b1);
    checkOutput("t4_3f_at", 32'(spawnAt), 32'd1);
    checkOutput("t4_3f_val", 32'(spawnVal), 32'b010);

    // Freeze with 25 cooldown frames left, then resume.
    applyStimulus(35, 1'b0);
    checkOutput("t5_pre_no_spawn", 32'(spawnCount), 32'd0);
    run_i = 1'b0;
    applyStimulus(100, 1'b0);
    checkOutput("t5_frozen_no_spawn", 32'(spawnCount), 32'd0);
    checkOutput("t5_frozen_level", 32'(level_o), 32'd0);
    run_i = 1'b1;
    applyStimulus(100, 1'b1);
    checkOutput("t5_resume_at", 32'(spawnAt), 32'd26);
    checkOutput("t5_resume_val", 32'(spawnVal), 32'b100);

    // Level 6 -> 7 in the same frame as a grant: that gap uses level 6 (36), the next uses 32.
    rand_i      = 16'h0000;
    slot_free_i = 3'b000;
    doClear();
    applyStimulus(2099, 1'b0);
    checkOutput("t6_level6", 32'(level_o), 32'd6);
    slot_free_i = 3'b111;
    applyStimulus(1, 1'b1);
    checkOutput("t6_g0_val", 32'(spawnVal), 32'b001);
    checkOutput("t6_level7", 32'(level_o), 32'd7);
    applyStimulus(100, 1'b1);
    checkOutput("t6_gap36_at", 32'(spawnAt), 32'd37);
    checkOutput("t6_gap36_val", 32'(spawnVal), 32'b010);
    rand_i = 16'h00B0;
    applyStimulus(33, 1'b0);
    checkOutput("t6_b0_no_spawn", 32'(spawnCount), 32'd0);
    checkOutput("t6_armed_lvl7", 32'(armed_o), 32'd1);
    rand_i = 16'h00AF;
    applyStimulus(1, 1'b1);
    checkOutput("t6_af_val", 32'(spawnVal), 32'b100);
    slot_free_i = 3'b000;
    applyStimulus(300, 1'b0);
    checkOutput("t6_level_sat", 32'(level_o), 32'd7);
    checkOutput("t6_armed_before_clear", 32'(armed_o), 32'd1);

    slot_free_i = 3'b111;
    rand_i      = 16'h0000;
    @(negedge clk_i);
    frame_i = 1'b1;
    clear_i = 1'b1;
    #1;
    checkOutput("t6_clear_spawn", 32'(spawn_o), 32'h0);
    @(negedge clk_i);
    frame_i = 1'b0;
    clear_i = 1'b0;
    checkOutput("t6_clear_level", 32'(level_o), 32'd0);
    checkOutput("t6_clear_armed", 32'(armed_o), 32'd0);

    // Async reset mid-cooldown; afterwards a full 60-frame gap must be reloaded.
    applyStimulus(10, 1'b0);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_spawn", 32'(spawn_o), 32'h0);
    checkOutput("t6_rst_level", 32'(level_o), 32'd0);
    checkOutput("t6_rst_armed", 32'(armed_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(100, 1'b1);
    checkOutput("t6_post_rst_at", 32'(spawnAt), 32'd61);
    checkOutput("t6_post_rst_val", 32'(spawnVal), 32'b010);

    checkOutput("never_multi_hot", 32'(sawMulti), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
